// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the switch debouncer.
// State encoding is fixed so the FSM can be probed by downstream exercise logic.
package switch_debouncer_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      PEND_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      PEND_LOW  = 2'd3
   } state_e;

   localparam int unsigned DEF_STABLE_CYCLES = 8;
   localparam int unsigned DEF_CNT_WIDTH     = 4;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronises a raw switch, accepts a level change only after it has held
// stable for STABLE_CYCLES samples, and emits registered level, rise/fall strobes and a toggle.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
   input  logic input_clock1_1,
   input  logic input_reset_n2_2,
   input  logic input_input_switch3_3,
   output logic output_led1_0_4,
   output logic output_led2_0_5,
   output logic output_led3_0_6,
   output logic output_led4_0_7
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

   logic                 sync2;
   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 level_q, level_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic                 toggle_q, toggle_d;

   sync_2ff u_sync (
      .clk   (input_clock1_1),
      .rst_n (input_reset_n2_2),
      .d     (input_input_switch3_3),
      .q     (sync2)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      level_d  = level_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      toggle_d = toggle_q;
      unique case (state_q)
         IDLE_LOW: begin
            if (sync2) begin
               state_d = PEND_HIGH;
               cnt_d   = CNT_WIDTH'(1);
            end else begin
               cnt_d = '0;
            end
         end
         PEND_HIGH: begin
            if (!sync2) begin
               // Bounce: drop the pending change silently.
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = IDLE_HIGH;
               cnt_d    = '0;
               level_d  = 1'b1;
               rise_d   = 1'b1;
               toggle_d = ~toggle_q;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         IDLE_HIGH: begin
            if (!sync2) begin
               state_d = PEND_LOW;
               cnt_d   = CNT_WIDTH'(1);
            end else begin
               cnt_d = '0;
            end
         end
         PEND_LOW: begin
            if (sync2) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge input_clock1_1 or negedge input_reset_n2_2) begin
      if (!input_reset_n2_2) begin
         state_q  <= IDLE_LOW;
         cnt_q    <= '0;
         level_q  <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         toggle_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         toggle_q <= toggle_d;
      end
   end

   assign output_led1_0_4 = level_q;
   assign output_led2_0_5 = rise_q;
   assign output_led3_0_6 = fall_q;
   assign output_led4_0_7 = toggle_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity, all compared
// against a run-length model of the debouncing rule.
module tb_switch_debouncer;

   localparam int unsigned S = 8;

   logic clk;
   logic rst_n;
   logic sw;
   logic led1, led2, led3, led4;

   int errors = 0;
   int checks = 0;

   // Reference model: two-sample input delay, then a count of consecutive samples that
   // disagree with the accepted level; S such samples flip the level.
   logic m_s1, m_s2, m_lvl, m_rise, m_fall, m_tog;
   int   m_run;

   switch_debouncer #(
      .STABLE_CYCLES (S),
      .CNT_WIDTH     (4)
   ) dut (
      .input_clock1_1        (clk),
      .input_reset_n2_2      (rst_n),
      .input_input_switch3_3 (sw),
      .output_led1_0_4       (led1),
      .output_led2_0_5       (led2),
      .output_led3_0_6       (led3),
      .output_led4_0_7       (led4)
   );

   initial begin
      clk = 1'b0;
      forever #50 clk = ~clk;
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".level"}, led1, m_lvl);
      chk({tag, ".rise"}, led2, m_rise);
      chk({tag, ".fall"}, led3, m_fall);
      chk({tag, ".toggle"}, led4, m_tog);
   endtask

   task automatic model_reset();
      m_s1   = 1'b0;
      m_s2   = 1'b0;
      m_lvl  = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_tog  = 1'b0;
      m_run  = 0;
   endtask

   // Drive the switch, advance one rising edge, update the model, then compare.
   task automatic step(input logic s, input string tag);
      logic smp;
      sw = s;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         smp    = m_s2;
         m_s2   = m_s1;
         m_s1   = s;
         m_rise = 1'b0;
         m_fall = 1'b0;
         m_run  = (smp != m_lvl) ? m_run + 1 : 0;
         if (m_run == S) begin
            m_lvl = smp;
            m_run = 0;
            if (smp) begin
               m_rise = 1'b1;
               m_tog  = ~m_tog;
            end else begin
               m_fall = 1'b1;
            end
         end
      end
      #1;
      check_all(tag);
   endtask

   task automatic set_reset(input logic v, input string tag);
      rst_n = v;
      if (!v) model_reset();
      #1;
      check_all(tag);
   endtask

   initial begin
      int len;
      logic val;
      rst_n = 1'b0;
      sw    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset_init");

      // Switch toggling while reset is held.
      for (int i = 0; i < 6; i++) step(logic'(i % 2), "reset_hold");
      sw = 1'b0;
      set_reset(1'b1, "reset_release");
      for (int i = 0; i < 20; i++) step(1'b0, "idle_low");

      // Clean press.
      for (int i = 1; i <= 11; i++) begin
         step(1'b1, "press");
         if (i == 9) chk("press_e9_level", led1, 1'b0);
         if (i == 10) begin
            chk("press_e10_level", led1, 1'b1);
            chk("press_e10_rise", led2, 1'b1);
            chk("press_e10_toggle", led4, 1'b1);
         end
         if (i == 11) chk("press_e11_rise", led2, 1'b0);
      end

      // Release.
      for (int i = 1; i <= 11; i++) begin
         step(1'b0, "release");
         if (i == 10) begin
            chk("release_e10_fall", led3, 1'b1);
            chk("release_e10_level", led1, 1'b0);
            chk("release_e10_toggle", led4, 1'b1);
         end
         if (i == 11) chk("release_e11_fall", led3, 1'b0);
      end

      // Second press returns the toggle to 0.
      for (int i = 1; i <= 11; i++) step(1'b1, "press2");
      chk("press2_toggle", led4, 1'b0);
      for (int i = 1; i <= 12; i++) step(1'b0, "release2");

      // Bounce: 4 high, 2 low, then held high.
      for (int i = 0; i < 4; i++) step(1'b1, "bounce_hi");
      for (int i = 0; i < 2; i++) step(1'b0, "bounce_lo");
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, "bounce_hold");
         if (i == 9) chk("bounce_e9_level", led1, 1'b0);
         if (i == 10) chk("bounce_e10_level", led1, 1'b1);
      end
      for (int i = 1; i <= 12; i++) step(1'b0, "release3");

      // Reset during a pending rise.
      for (int i = 0; i < 6; i++) step(1'b1, "midpend");
      set_reset(1'b0, "midpend_rst");
      step(1'b1, "midpend_rst_hold");
      step(1'b1, "midpend_rst_hold");
      set_reset(1'b1, "midpend_release");
      for (int i = 1; i <= 11; i++) begin
         step(1'b1, "post_reset");
         if (i == 9) chk("post_reset_e9_rise", led2, 1'b0);
         if (i == 10) chk("post_reset_e10_rise", led2, 1'b1);
      end

      // Random switch activity with occasional resets.
      for (int b = 0; b < 60; b++) begin
         val = logic'($urandom_range(0, 1));
         len = int'($urandom_range(1, 14));
         for (int i = 0; i < len; i++) step(val, "random");
         if ($urandom_range(0, 19) == 0) begin
            set_reset(1'b0, "random_rst");
            step(logic'($urandom_range(0, 1)), "random_rst_hold");
            set_reset(1'b1, "random_rst_release");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
